// File: rtl/router_pkg.sv
// Shared types and constants for the router output-port reader.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } rd_state_t;

  // Header byte layout is {len, addr}.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] h);
    return h[DATA_W-1:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] h);
    return h[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes; load starts a new packet.
module router_parity_acc #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  // Clear wins over load, load wins over accumulate.
  always_ff @(posedge clock) begin
    if (reset || clr)  acc <= '0;
    else if (load)     acc <= din;
    else if (acc_en)   acc <= acc ^ din;
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Output-port reader: drains the port FIFO, parses header/payload/parity,
// streams bytes to the local sink and flags parity errors or soft-reset aborts.
// Optional: define ROUTER_RD_ERR_CNT_EN to add a saturating err_cnt output.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int LEN_W  = router_pkg::LEN_W,
  parameter int ADDR_W = router_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vld_out,
  input  logic [DATA_W-1:0] data_out,
  input  logic              soft_reset,
  input  logic              sink_ready,
  output logic              read_enb,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_data_vld,
  output logic              pkt_sop,
  output logic              pkt_eop,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              parity_err,
  output logic              pkt_abort,
  output logic              busy
`ifdef ROUTER_RD_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  rd_state_t         state_q, state_d;
  logic              inflight_q;
  logic [LEN_W:0]    req_cnt_q;   // bytes requested this packet, up to len+2
  logic [LEN_W-1:0]  pay_cnt_q;   // payload bytes received
  logic [LEN_W:0]    req_lim;
  logic              arrive, hdr_arr, pay_arr, par_arr, abort;
  logic [DATA_W-1:0] acc;

  assign busy = (state_q != IDLE);

  // Request gating and next-state decode. While the header is arriving its
  // length is taken straight off data_out so the payload can stream back-to-back.
  always_comb begin
    state_d  = state_q;
    hdr_arr  = 1'b0;
    pay_arr  = 1'b0;
    par_arr  = 1'b0;
    abort    = 1'b0;
    arrive   = inflight_q & ~soft_reset;
    req_lim  = (state_q == HDR) ? {1'b0, hdr_len(data_out)} + (LEN_W+1)'(2)
                                : {1'b0, pkt_len} + (LEN_W+1)'(2);
    read_enb = vld_out & sink_ready & ~soft_reset & ~reset;
    case (state_q)
      IDLE:    ;
      HDR:     read_enb = read_enb & inflight_q & (req_cnt_q < req_lim);
      default: read_enb = read_enb & (req_cnt_q < req_lim);
    endcase
    if (soft_reset && state_q != IDLE) begin
      abort   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (read_enb) state_d = HDR;
        HDR:     if (arrive) begin
                   hdr_arr = 1'b1;
                   state_d = (hdr_len(data_out) != '0) ? PAYLOAD : PARITY;
                 end
        PAYLOAD: if (arrive) begin
                   pay_arr = 1'b1;
                   if (pay_cnt_q + LEN_W'(1) == pkt_len) state_d = PARITY;
                 end
        PARITY:  if (arrive) begin
                   par_arr = 1'b1;
                   state_d = IDLE;
                 end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath: in-flight tracking, counters and registered sink outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q   <= 1'b0;
      req_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      pkt_data     <= '0;
      pkt_data_vld <= 1'b0;
      pkt_sop      <= 1'b0;
      pkt_eop      <= 1'b0;
      pkt_addr     <= '0;
      pkt_len      <= '0;
      parity_err   <= 1'b0;
      pkt_abort    <= 1'b0;
    end else begin
      inflight_q   <= read_enb;
      pkt_data_vld <= hdr_arr | pay_arr;
      pkt_sop      <= hdr_arr;
      pkt_eop      <= par_arr;
      parity_err   <= par_arr & (data_out != acc);
      pkt_abort    <= abort;
      if (hdr_arr | pay_arr) pkt_data <= data_out;
      if (hdr_arr) begin
        pkt_addr <= hdr_addr(data_out);
        pkt_len  <= hdr_len(data_out);
      end
      if (abort || par_arr) req_cnt_q <= '0;
      else if (read_enb)    req_cnt_q <= req_cnt_q + (LEN_W+1)'(1);
      if (abort || par_arr || hdr_arr) pay_cnt_q <= '0;
      else if (pay_arr)                pay_cnt_q <= pay_cnt_q + LEN_W'(1);
    end
  end

  router_parity_acc #(.DATA_W(DATA_W)) u_acc (
    .clock  (clock),
    .reset  (reset),
    .clr    (abort | par_arr),
    .load   (hdr_arr),
    .acc_en (pay_arr),
    .din    (data_out),
    .acc    (acc)
  );

`ifdef ROUTER_RD_ERR_CNT_EN
  // Saturating count of parity errors and aborts.
  always_ff @(posedge clock) begin
    if (reset) err_cnt <= '0;
    else if ((parity_err || pkt_abort) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule
